// File: rtl/gpio_in.sv
// -----------------------------------------------------------------------------
// gpio_in -- debounced general-purpose input block with edge capture and IRQ.
//
// Each pin is brought into the clk domain by a two-flop synchronizer. It is
// then debounced: the pin's accepted level (state) only follows the
// synchronized level after DEBOUNCE consecutive cycles of disagreement. Rising
// and falling transitions of state are latched into sticky RISE/FALL bits,
// which software clears by writing 1s. The interrupt request is raised while
// any latched edge is enabled in IRQ_EN.
//
// Ports:
//   clk       sole clock, rising edge
//   rst       asynchronous active-high reset
//   pin_in    external pins, asynchronous to clk
//   addr      register select: 0 DATA (ro), 1 RISE (w1c), 2 FALL (w1c), 3 IRQ_EN (rw)
//   wr_en     write strobe
//   wdata     write data
//   rd_en     read strobe
//   rdata     registered read data, holds its value between reads
//   rd_valid  one-cycle pulse marking rdata valid
//   irq       level interrupt, OR of enabled RISE/FALL bits
// -----------------------------------------------------------------------------
module gpio_in #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [1:0]       addr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             rd_valid,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_RISE   = 2'd1;
  localparam logic [1:0] ADDR_FALL   = 2'd2;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd3;

  // The counter reaching DEBOUNCE-1 means the current mismatch is the
  // DEBOUNCE-th in a row, so state is accepted on this edge.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  logic [WIDTH-1:0]      sync1_q;
  logic [WIDTH-1:0]      sync2_q;
  logic [WIDTH-1:0]      state_q,  state_d;
  logic [WIDTH-1:0][7:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0]      rise_q,   rise_d;
  logic [WIDTH-1:0]      fall_q,   fall_d;
  logic [WIDTH-1:0]      irq_en_q, irq_en_d;
  logic [WIDTH-1:0]      rdata_q,  rdata_d;
  logic                  rd_valid_q;
  logic [WIDTH-1:0]      rise_clr_s;
  logic [WIDTH-1:0]      fall_clr_s;

  // Per-pin debounce: count consecutive mismatches, accept on the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != state_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          state_d[i] = sync2_q[i];
          cnt_d[i]   = 8'd0;
        end else begin
          cnt_d[i]   = cnt_q[i] + 8'd1;
        end
      end else begin
        cnt_d[i] = 8'd0;
      end
    end
  end

  // Edge capture with write-1-to-clear; a same-cycle set overrides the clear.
  always_comb begin
    rise_clr_s = {WIDTH{1'b0}};
    fall_clr_s = {WIDTH{1'b0}};
    irq_en_d   = irq_en_q;
    if (wr_en) begin
      case (addr)
        ADDR_RISE:   rise_clr_s = wdata;
        ADDR_FALL:   fall_clr_s = wdata;
        ADDR_IRQ_EN: irq_en_d   = wdata;
        ADDR_DATA:   irq_en_d   = irq_en_q;
        default:     irq_en_d   = irq_en_q;
      endcase
    end else begin
      irq_en_d = irq_en_q;
    end
    rise_d = (rise_q & ~rise_clr_s) | (state_d & ~state_q);
    fall_d = (fall_q & ~fall_clr_s) | (~state_d & state_q);
  end

  // Read mux; samples register contents before any same-cycle write lands.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        ADDR_DATA:   rdata_d = state_q;
        ADDR_RISE:   rdata_d = rise_q;
        ADDR_FALL:   rdata_d = fall_q;
        ADDR_IRQ_EN: rdata_d = irq_en_q;
        default:     rdata_d = {WIDTH{1'b0}};
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // All state registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= {WIDTH{1'b0}};
      sync2_q    <= {WIDTH{1'b0}};
      state_q    <= {WIDTH{1'b0}};
      cnt_q      <= {WIDTH{8'd0}};
      rise_q     <= {WIDTH{1'b0}};
      fall_q     <= {WIDTH{1'b0}};
      irq_en_q   <= {WIDTH{1'b0}};
      rdata_q    <= {WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      sync1_q    <= pin_in;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      irq_en_q   <= irq_en_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
  // Straight from flops so the interrupt tracks clears with no extra cycle.
  assign irq      = |((rise_q | fall_q) & irq_en_q);

endmodule

// File: doc/gpio_in.md
GPIO_IN -- requirements
Module: gpio_in

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of input pins and the data width of every register.
REQ-002 Parameter DEBOUNCE, default 4, sets the consecutive mismatch cycles required to accept a pin change; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pin_in  input  WIDTH  external pins, asynchronous to clk.
REQ-006 addr  input  2  register select: 0 DATA, 1 RISE, 2 FALL, 3 IRQ_EN.
REQ-007 wr_en  input  1  write strobe, one write per cycle asserted.
REQ-008 wdata  input  WIDTH  write data.
REQ-009 rd_en  input  1  read strobe, one read per cycle asserted.
REQ-010 rdata  output  WIDTH  registered read data.
REQ-011 rd_valid  output  1  one-cycle pulse marking rdata valid.
REQ-012 irq  output  1  level interrupt request.

Function
REQ-013 Each pin SHALL pass through a 2-flop synchronizer; the second flop output is sync[i].
REQ-014 Per pin, an 8-bit counter SHALL clear on any edge where sync[i]==state[i] and increment where they differ.
REQ-015 state[i] SHALL take sync[i] on the DEBOUNCE-th consecutive edge with sync[i]!=state[i], and the counter SHALL clear on that edge.
REQ-016 Latency: pin change captured at edge N -> state change at edge N+1+DEBOUNCE (edge N+5 at default).
REQ-017 A pin pulse shorter than DEBOUNCE synchronized cycles SHALL leave state, RISE and FALL unchanged.
REQ-018 DATA register SHALL read state[WIDTH-1:0]; writes to DATA are ignored.
REQ-019 RISE[i] SHALL set on the edge state[i] goes 0->1; FALL[i] SHALL set on the edge state[i] goes 1->0; both are sticky.
REQ-020 A write to RISE or FALL SHALL clear each bit where wdata is 1 (write-1-to-clear); bits where wdata is 0 are unchanged.
REQ-021 Set and write-1-to-clear on the same bit in the same cycle: set SHALL win.
REQ-022 IRQ_EN SHALL be read/write; a write loads wdata fully.
REQ-023 irq SHALL equal OR over i of ((RISE[i] | FALL[i]) & IRQ_EN[i]), combinational from flops, no added latency.
REQ-024 rd_en at edge N SHALL load rdata with the addressed register and pulse rd_valid high for the cycle after edge N.
REQ-025 rdata SHALL hold its last value when rd_en is low; reads SHALL have no side effects.
REQ-026 rd_en and wr_en in the same cycle: both performed; rdata SHALL return the pre-write value.
REQ-027 Debounce operation SHALL continue unaffected by bus activity.

Reset
REQ-028 While rst is high: sync, state, counters, RISE, FALL, IRQ_EN, rdata = 0; rd_valid = 0; irq = 0.
REQ-029 Reset asserted mid-debounce SHALL discard the partial count.
REQ-030 Pins high at reset release SHALL produce a normal debounced rise (RISE set) after DEBOUNCE+2 edges.

Verification
REQ-031 Reset, then pin_in=8'h01 stable from edge N -> DATA=8'h01 at edge N+5, RISE=8'h01, irq stays 0 (IRQ_EN=0).
REQ-032 Pin 3 pulsed high for 3 cycles (DEBOUNCE=4) -> DATA, RISE and FALL remain 8'h00.
REQ-033 IRQ_EN=8'h01, pin 0 rise then fall -> irq=1 with RISE=FALL=8'h01; write 8'h01 to RISE keeps irq=1; then write 8'h01 to FALL -> irq=0 next cycle.
REQ-034 A new rise on pin 2 coinciding with a write of 8'hFF to RISE -> RISE[2]=1 afterwards, all other bits 0.
REQ-035 rd_en with addr=3 and wr_en with addr=3 and wdata=8'hA5 in the same cycle, prior IRQ_EN=8'h3C -> rdata=8'h3C with rd_valid=1 the next cycle, then IRQ_EN reads 8'hA5.
REQ-036 rst asserted with counter at 2, pin still changed -> after release, state changes only DEBOUNCE+2 edges later.
